// File: rtl/l2_mem_arbiter_if.sv
// Bundle of the two L1 client ports, the backing-memory port and the service counters
// of the L2 memory arbiter.
// slave: the arbiter's own view. master: the view of the caches and memory around it.
interface l2_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned DATA_W = 128
);
  // I-cache client (read-only)
  logic              ic_mem_read;
  logic [ADDR_W-1:0] ic_mem_addr;
  logic [DATA_W-1:0] ic_mem_rdata;
  logic              ic_mem_ready;
  // D-cache client (read/write)
  logic              dc_mem_read;
  logic              dc_mem_write;
  logic [ADDR_W-1:0] dc_mem_addr;
  logic [DATA_W-1:0] dc_mem_wdata;
  logic [DATA_W-1:0] dc_mem_rdata;
  logic              dc_mem_ready;
  // Backing memory
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  // Completed-transaction counters
  logic [31:0]       ic_served_cnt;
  logic [31:0]       dc_served_cnt;

  modport slave (
    input  ic_mem_read, ic_mem_addr,
    output ic_mem_rdata, ic_mem_ready,
    input  dc_mem_read, dc_mem_write, dc_mem_addr, dc_mem_wdata,
    output dc_mem_rdata, dc_mem_ready,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready,
    output ic_served_cnt, dc_served_cnt
  );

  modport master (
    output ic_mem_read, ic_mem_addr,
    input  ic_mem_rdata, ic_mem_ready,
    output dc_mem_read, dc_mem_write, dc_mem_addr, dc_mem_wdata,
    input  dc_mem_rdata, dc_mem_ready,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready,
    input  ic_served_cnt, dc_served_cnt
  );
endinterface

// File: rtl/l2_mem_arbiter.sv
// Round-robin arbiter putting the I-cache and D-cache block ports onto one L2 port.
// One block transaction at a time; client read data is registered and held.
module l2_mem_arbiter #(
  parameter int unsigned ADDR_W  = 28,
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned HOLDOFF = 2
) (
  input  logic             clk,
  input  logic             proc_reset_n,
  l2_mem_arbiter_if.slave  bus
);

  localparam int unsigned HoldW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  typedef enum logic [1:0] {StIdle, StServeIc, StServeDc} state_e;
  typedef enum logic {GrantIc = 1'b0, GrantDc = 1'b1} grant_e;

  state_e            state_q, state_d;
  grant_e            last_grant_q, last_grant_d;
  logic [HoldW-1:0]  ic_hold_q, ic_hold_d;
  logic [HoldW-1:0]  dc_hold_q, dc_hold_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] ic_rdata_q, ic_rdata_d;
  logic [DATA_W-1:0] dc_rdata_q, dc_rdata_d;
  logic              ic_ready_q, ic_ready_d;
  logic              dc_ready_q, dc_ready_d;
  logic [31:0]       ic_cnt_q, ic_cnt_d;
  logic [31:0]       dc_cnt_q, dc_cnt_d;

  logic ic_req;
  logic dc_req;

  // A client still holding its request just after a completion is masked by its holdoff
  assign ic_req = bus.ic_mem_read && (ic_hold_q == '0);
  assign dc_req = (bus.dc_mem_read || bus.dc_mem_write) && (dc_hold_q == '0);

  // Next-state: grant in idle, hold the memory port while serving, retire on mem_ready
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    ic_hold_d    = (ic_hold_q != '0) ? ic_hold_q - HoldW'(1) : '0;
    dc_hold_d    = (dc_hold_q != '0) ? dc_hold_q - HoldW'(1) : '0;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    ic_rdata_d   = ic_rdata_q;
    dc_rdata_d   = dc_rdata_q;
    ic_ready_d   = 1'b0;
    dc_ready_d   = 1'b0;
    ic_cnt_d     = ic_cnt_q;
    dc_cnt_d     = dc_cnt_q;

    unique case (state_q)
      StIdle: begin
        // DC wins when alone, or on a tie when IC was served last
        if (dc_req && (!ic_req || last_grant_q == GrantIc)) begin
          // Read/write forwarded as-is; both set together is not filtered
          mem_read_d  = bus.dc_mem_read;
          mem_write_d = bus.dc_mem_write;
          mem_addr_d  = bus.dc_mem_addr;
          mem_wdata_d = bus.dc_mem_wdata;
          state_d     = StServeDc;
        end else if (ic_req) begin
          mem_read_d  = 1'b1;
          mem_write_d = 1'b0;
          mem_addr_d  = bus.ic_mem_addr;
          state_d     = StServeIc;
        end
      end
      StServeIc: begin
        if (bus.mem_ready) begin
          ic_rdata_d   = bus.mem_rdata;
          ic_ready_d   = 1'b1;
          mem_read_d   = 1'b0;
          mem_write_d  = 1'b0;
          ic_cnt_d     = ic_cnt_q + 32'd1;
          last_grant_d = GrantIc;
          ic_hold_d    = HoldW'(HOLDOFF);
          state_d      = StIdle;
        end
      end
      StServeDc: begin
        if (bus.mem_ready) begin
          // A write returns no data, so the held read block is left alone
          if (!mem_write_q) begin
            dc_rdata_d = bus.mem_rdata;
          end
          dc_ready_d   = 1'b1;
          mem_read_d   = 1'b0;
          mem_write_d  = 1'b0;
          dc_cnt_d     = dc_cnt_q + 32'd1;
          last_grant_d = GrantDc;
          dc_hold_d    = HoldW'(HOLDOFF);
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous active-low reset; reset abandons any in-flight access
  always_ff @(posedge clk) begin
    if (!proc_reset_n) begin
      state_q      <= StIdle;
      last_grant_q <= GrantIc;
      ic_hold_q    <= '0;
      dc_hold_q    <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      ic_rdata_q   <= '0;
      dc_rdata_q   <= '0;
      ic_ready_q   <= 1'b0;
      dc_ready_q   <= 1'b0;
      ic_cnt_q     <= '0;
      dc_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      ic_hold_q    <= ic_hold_d;
      dc_hold_q    <= dc_hold_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      ic_rdata_q   <= ic_rdata_d;
      dc_rdata_q   <= dc_rdata_d;
      ic_ready_q   <= ic_ready_d;
      dc_ready_q   <= dc_ready_d;
      ic_cnt_q     <= ic_cnt_d;
      dc_cnt_q     <= dc_cnt_d;
    end
  end

  assign bus.mem_read      = mem_read_q;
  assign bus.mem_write     = mem_write_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.ic_mem_rdata  = ic_rdata_q;
  assign bus.dc_mem_rdata  = dc_rdata_q;
  assign bus.ic_mem_ready  = ic_ready_q;
  assign bus.dc_mem_ready  = dc_ready_q;
  assign bus.ic_served_cnt = ic_cnt_q;
  assign bus.dc_served_cnt = dc_cnt_q;

endmodule

// File: tb/tb_l2_mem_arbiter.sv
// Directed bench for l2_mem_arbiter: each step drives inputs, advances one clock and
// compares outputs against hand-computed values.
module tb_l2_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   total  = 0;
  int   passed = 0;

  logic [127:0] pat_a5;
  logic [127:0] pat_d1;
  logic [127:0] pat_i2;
  logic [127:0] pat_wr;
  logic [127:0] pat_junk;
  logic [127:0] pat_77;

  always #5 clk = ~clk;

  l2_mem_arbiter_if #(.ADDR_W(28), .DATA_W(128)) bus ();

  l2_mem_arbiter #(.ADDR_W(28), .DATA_W(128), .HOLDOFF(2)) dut (
    .clk          (clk),
    .proc_reset_n (rst_n),
    .bus          (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    pat_a5   = {16{8'hA5}};
    pat_d1   = {16{8'hD1}};
    pat_i2   = {16{8'h12}};
    pat_wr   = 128'h0123456789ABCDEF0123456789ABCDEF;
    pat_junk = {8{16'hDEAD}};
    pat_77   = {16{8'h77}};

    rst_n            = 1'b0;
    bus.ic_mem_read  = 1'b0;
    bus.ic_mem_addr  = '0;
    bus.dc_mem_read  = 1'b0;
    bus.dc_mem_write = 1'b0;
    bus.dc_mem_addr  = '0;
    bus.dc_mem_wdata = '0;
    bus.mem_rdata    = '0;
    bus.mem_ready    = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_mem_read",  bus.mem_read,      0);
    check("rst_mem_write", bus.mem_write,     0);
    check("rst_mem_addr",  bus.mem_addr,      0);
    check("rst_ic_ready",  bus.ic_mem_ready,  0);
    check("rst_dc_ready",  bus.dc_mem_ready,  0);
    check("rst_ic_rdata",  bus.ic_mem_rdata,  0);
    check("rst_ic_cnt",    bus.ic_served_cnt, 0);
    check("rst_dc_cnt",    bus.dc_served_cnt, 0);
    rst_n = 1'b1;

    // Single IC read, memory answers 3 cycles after the strobe rises
    bus.ic_mem_read = 1'b1;
    bus.ic_mem_addr = 28'h0000010;
    check("ic1_no_strobe_yet", bus.mem_read, 0);
    tick();
    check("ic1_mem_read", bus.mem_read, 1);
    check("ic1_mem_addr", bus.mem_addr, 28'h0000010);
    check("ic1_mem_write", bus.mem_write, 0);
    tick();
    tick();
    check("ic1_strobe_held", bus.mem_read, 1);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = pat_a5;
    tick();
    check("ic1_ready_pulse", bus.ic_mem_ready, 1);
    check("ic1_rdata", bus.ic_mem_rdata, pat_a5);
    check("ic1_strobe_clear", bus.mem_read, 0);
    check("ic1_cnt", bus.ic_served_cnt, 1);
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    // IC keeps its request up through the pulse cycle and the next one
    tick();
    check("hold_ready_one_cycle", bus.ic_mem_ready, 0);
    check("hold_no_reissue_a", bus.mem_read, 0);
    tick();
    check("hold_no_reissue_b", bus.mem_read, 0);
    bus.ic_mem_read = 1'b0;
    tick();
    check("hold_no_reissue_c", bus.mem_read, 0);
    check("hold_cnt", bus.ic_served_cnt, 1);
    check("ic1_rdata_held", bus.ic_mem_rdata, pat_a5);

    // Simultaneous IC and DC reads straight after reset: DC first
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.ic_mem_read = 1'b1;
    bus.ic_mem_addr = 28'h0000020;
    bus.dc_mem_read = 1'b1;
    bus.dc_mem_addr = 28'h0000030;
    tick();
    check("tie_dc_first_addr", bus.mem_addr, 28'h0000030);
    check("tie_dc_read", bus.mem_read, 1);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = pat_d1;
    tick();
    check("tie_dc_ready", bus.dc_mem_ready, 1);
    check("tie_ic_not_ready", bus.ic_mem_ready, 0);
    check("tie_dc_rdata", bus.dc_mem_rdata, pat_d1);
    check("tie_gap_low", bus.mem_read, 0);
    bus.dc_mem_read = 1'b0;
    bus.mem_ready   = 1'b0;
    tick();
    check("tie_ic_second_read", bus.mem_read, 1);
    check("tie_ic_second_addr", bus.mem_addr, 28'h0000020);
    check("tie_dc_pulse_done", bus.dc_mem_ready, 0);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = pat_i2;
    tick();
    check("tie_ic_ready", bus.ic_mem_ready, 1);
    check("tie_ic_rdata", bus.ic_mem_rdata, pat_i2);
    check("tie_ic_cnt", bus.ic_served_cnt, 1);
    check("tie_dc_cnt", bus.dc_served_cnt, 1);
    bus.ic_mem_read = 1'b0;
    bus.mem_ready   = 1'b0;
    tick();
    tick();

    // DC write; a change of client inputs while serving is ignored
    bus.dc_mem_write = 1'b1;
    bus.dc_mem_addr  = 28'h00000FF;
    bus.dc_mem_wdata = pat_wr;
    tick();
    check("wr_mem_write", bus.mem_write, 1);
    check("wr_mem_read", bus.mem_read, 0);
    check("wr_mem_addr", bus.mem_addr, 28'h00000FF);
    check("wr_mem_wdata", bus.mem_wdata, pat_wr);
    bus.dc_mem_addr  = 28'h0000055;
    bus.dc_mem_wdata = '0;
    tick();
    check("wr_addr_held", bus.mem_addr, 28'h00000FF);
    check("wr_wdata_held", bus.mem_wdata, pat_wr);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = pat_junk;
    tick();
    check("wr_dc_ready", bus.dc_mem_ready, 1);
    check("wr_rdata_unchanged", bus.dc_mem_rdata, pat_d1);
    check("wr_strobe_clear", bus.mem_write, 0);
    check("wr_dc_cnt", bus.dc_served_cnt, 2);
    bus.dc_mem_write = 1'b0;
    bus.mem_ready    = 1'b0;
    tick();
    tick();

    // Reset in the middle of a DC read
    bus.dc_mem_read = 1'b1;
    bus.dc_mem_addr = 28'h0000040;
    tick();
    check("mid_dc_serving", bus.mem_read, 1);
    rst_n = 1'b0;
    tick();
    check("mid_rst_mem_read", bus.mem_read, 0);
    check("mid_rst_mem_addr", bus.mem_addr, 0);
    check("mid_rst_dc_rdata", bus.dc_mem_rdata, 0);
    check("mid_rst_ic_rdata", bus.ic_mem_rdata, 0);
    check("mid_rst_dc_cnt", bus.dc_served_cnt, 0);
    check("mid_rst_ic_cnt", bus.ic_served_cnt, 0);
    rst_n = 1'b1;
    bus.ic_mem_read = 1'b1;
    bus.ic_mem_addr = 28'h0000050;
    tick();
    check("mid_fresh_dc_priority", bus.mem_addr, 28'h0000040);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = pat_77;
    tick();
    check("mid_dc_ready", bus.dc_mem_ready, 1);
    check("mid_dc_cnt", bus.dc_served_cnt, 1);
    check("mid_dc_rdata", bus.dc_mem_rdata, pat_77);
    bus.dc_mem_read = 1'b0;
    bus.mem_ready   = 1'b0;
    tick();
    check("mid_ic_next_addr", bus.mem_addr, 28'h0000050);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = pat_a5;
    tick();
    check("mid_ic_cnt", bus.ic_served_cnt, 1);
    bus.ic_mem_read = 1'b0;
    bus.mem_ready   = 1'b0;
    tick();
    tick();
    tick();

    // Served counter wraps from all-ones to zero
    force dut.ic_cnt_q = 32'hFFFFFFFF;
    #1;
    release dut.ic_cnt_q;
    check("wrap_preload", bus.ic_served_cnt, 32'hFFFFFFFF);
    bus.ic_mem_read = 1'b1;
    bus.ic_mem_addr = 28'h0000060;
    tick();
    check("wrap_mem_read", bus.mem_read, 1);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = pat_i2;
    tick();
    check("wrap_ready", bus.ic_mem_ready, 1);
    check("wrap_cnt_zero", bus.ic_served_cnt, 0);
    bus.ic_mem_read = 1'b0;
    bus.mem_ready   = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/l2_mem_arbiter.md
Name: l2_mem_arbiter

Overview:
- Arbitrates two L1 miss/writeback ports onto the single 128-bit backing-memory (L2) port: the instruction cache (read-only) and the data cache (read/write).
- Sits directly downstream of the I-cache and D-cache memory interfaces.
- Serves one 128-bit block transaction at a time, with round-robin arbitration.
- Returns registered, held read data so the L1 caches can capture it after their own registered-ready stage.

Parameters:
- ADDR_W, 28, block address width (word address bits above the 4-word block offset).
- DATA_W, 128, block width in bits.
- HOLDOFF, 2, cycles a just-served client's request stays masked after its ready pulse.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- proc_reset_n  in  1  synchronous, active-low reset.
- ic_mem_read  in  1  I-cache block read request, level, held until served.
- ic_mem_addr  in  ADDR_W  I-cache block address.
- ic_mem_rdata  out  DATA_W  block returned to I-cache.
- ic_mem_ready  out  1  one-cycle completion pulse to I-cache.
- dc_mem_read  in  1  D-cache block read request, level.
- dc_mem_write  in  1  D-cache block write request, level.
- dc_mem_addr  in  ADDR_W  D-cache block address.
- dc_mem_wdata  in  DATA_W  D-cache write block.
- dc_mem_rdata  out  DATA_W  block returned to D-cache.
- dc_mem_ready  out  1  one-cycle completion pulse to D-cache.
- mem_read  out  1  memory read strobe, level.
- mem_write  out  1  memory write strobe, level.
- mem_addr  out  ADDR_W  memory block address.
- mem_wdata  out  DATA_W  memory write block.
- mem_rdata  in  DATA_W  memory read block, valid while mem_ready=1.
- mem_ready  in  1  memory completion, one or more cycles.
- ic_served_cnt  out  32  count of completed I-cache transactions, wraps.
- dc_served_cnt  out  32  count of completed D-cache transactions, wraps.

Behaviour:
- Reset (proc_reset_n=0 at a clk edge):
  - State goes to IDLE.
  - All outputs go to 0: strobes, addr, wdata, both rdata, both ready, both counters.
  - Holdoff counters clear.
  - last_grant is set to IC, so the D-cache wins the first tie.
  - Reset mid-transaction abandons the in-flight access; mem_read/mem_write are low from the cycle after the reset edge.
- Request qualification:
  - ic_req = ic_mem_read AND ic holdoff counter == 0.
  - dc_req = (dc_mem_read OR dc_mem_write) AND dc holdoff counter == 0.
- State machine:
  - IDLE:
    - Neither request: stay in IDLE.
    - Exactly one request: grant that client.
    - Both requests: grant the client that is not last_grant.
    - On grant: register addr (plus wdata/write for DC) into mem_addr/mem_wdata/mem_read/mem_write, go to SERVE_IC or SERVE_DC.
    - Memory strobes first assert the cycle after the request is first seen in IDLE (1-cycle grant latency).
  - SERVE_x:
    - Memory outputs are held constant; a change on the client's inputs is ignored.
    - On a clk edge with mem_ready=1:
      - Latch mem_rdata into x_mem_rdata (DC write: rdata is not updated).
      - Pulse x_mem_ready for exactly the next cycle.
      - Clear mem_read/mem_write on that same edge.
      - Increment x_served_cnt.
      - Set last_grant=x.
      - Load x holdoff counter with HOLDOFF.
      - Go to IDLE.
- Client read data:
  - x_mem_rdata is registered and held until x's next read completion.
  - The L1 may sample it any number of cycles after the ready pulse.
- Holdoff:
  - A non-zero holdoff counter decrements by 1 per cycle.
  - It masks only its own client; the other client may be granted in the same IDLE cycle.
  - Purpose: an L1 sees ready through a registered stage and keeps its request high for up to HOLDOFF cycles after the pulse. This must not re-trigger a duplicate transaction.
- Back-to-back turnaround:
  - Minimum 1 IDLE cycle between transactions; mem strobes are low for at least 1 cycle between transactions.
- Simultaneous events:
  - A request arriving in the same cycle as mem_ready is not granted that cycle; it is evaluated in IDLE next cycle.
  - DC read and write asserted together is illegal. Forward both bits unchanged; no protection.
- Counter overflow: 32'hFFFFFFFF + 1 wraps to 0.

Test Plan:
- Reset, then IC read with addr 28'h0000010, mem_ready high 3 cycles later with mem_rdata=128'hA5...A5.
  - mem_read rises 1 cycle after the request, mem_addr=28'h0000010.
  - ic_mem_ready pulses once; ic_mem_rdata=A5...A5 and held.
  - ic_served_cnt=1.
- IC and DC reads asserted in the same cycle right after reset.
  - DC served first, then IC.
  - mem strobes low for exactly 1 cycle between them.
  - Two ready pulses in order DC then IC.
- IC keeps ic_mem_read high for 2 cycles after its ready pulse (HOLDOFF=2), DC idle.
  - No second mem_read is issued; the counter stays at 1.
- DC write of wdata=128'h0123...CDEF at addr 28'h00000FF.
  - mem_write=1 with matching addr/wdata until mem_ready.
  - dc_mem_rdata unchanged; dc_mem_ready pulses.
- proc_reset_n driven low during SERVE_DC with mem_ready low.
  - Next cycle all outputs are 0 and state is IDLE.
  - The next request is treated as fresh, with DC priority.
- Force ic_served_cnt to 32'hFFFFFFFF, then complete one IC read.
  - Counter reads 0.
